mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
Sequencer directly upstream of the mem_word array. It accepts read and write requests on a valid/ready handshake and decodes the address into a one-hot word select. It drives the rw/sel/data pins of the array with safe setup, pulse and hold timing for the level-sensitive latch cells. It returns read data or a write acknowledge on a response handshake.

Parameters:
- N_WORDS, 16: number of mem_word instances driven.
- ADDR_W, 4: request address width; must satisfy 2**ADDR_W >= N_WORDS.
- DATA_W, 8: word width; matches mem_word.
- WR_HOLD, 2: cycles for which sel and rw are both high during a write; minimum 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  error flag for the response.
- mem_rw  out  1  rw pin of every word; 1 = write, 0 = read.
- mem_sel  out  N_WORDS  one-hot word select.
- mem_wdata  out  DATA_W  shared inp bus to all words.
- mem_rdata  in  N_WORDS*DATA_W  concatenated word outputs; word i occupies bits [i*DATA_W +: DATA_W].
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous, active-low, and sampled on the clk rising edge.
  - Reset takes priority over everything, including an access in progress. It forces state to IDLE.
  - Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_rw=0, mem_sel=0, mem_wdata=0, busy=0.
- Registered outputs: all outputs are registered, except req_ready and busy, which decode the state register. mem_sel must never glitch.
- States: IDLE, SETUP, WPULSE, WHOLD, RSEL, RCAP, RESP.
- IDLE:
  - req_ready=1, mem_sel=0, mem_rw=0.
  - On req_valid&&req_ready, latch we, addr and wdata, then go to SETUP.
  - req_ready is low in all other states. Requests wait; nothing is dropped.
- SETUP (1 cycle):
  - mem_wdata = latched data for a write; for a read it holds its previous value.
  - mem_rw = we, mem_sel = 0.
  - Next state: write goes to WPULSE; read goes to RSEL.
  - Out-of-range address (addr >= N_WORDS) goes straight to RESP with rsp_err=1 and rsp_rdata=0. No select is asserted.
- WPULSE (WR_HOLD cycles, counted by an internal counter):
  - mem_sel = onehot(addr), mem_rw = 1, mem_wdata held.
  - Then go to WHOLD.
- WHOLD (1 cycle):
  - mem_sel = 0 while mem_rw stays 1 and mem_wdata stays held. Select falls before rw and data change.
  - Then go to RESP with rsp_rdata=0 and rsp_err=0.
- RSEL (1 cycle): mem_sel = onehot(addr), mem_rw = 0.
- RCAP (1 cycle):
  - mem_sel stays high.
  - At the end of the cycle, rsp_rdata is captured from the mem_rdata slice for addr and rsp_err is set to 0.
  - Then go to RESP; mem_sel falls to 0 on entry.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are stable until rsp_valid&&rsp_ready.
  - On that handshake, go to IDLE; rsp_valid=0.
- Latency (accept in cycle T, WR_HOLD=2):
  - Write: rsp_valid first high in cycle T+5, i.e. T+3+WR_HOLD.
  - Read: rsp_valid first high in cycle T+4.
  - With rsp_ready held high, back-to-back throughput is one request per (latency+1) cycles.
- Invariants:
  - At most one bit of mem_sel is high.
  - mem_sel is never high on the same cycle that mem_rw or mem_wdata changes.
  - Changes of req_* while busy are ignored.

Optional Feature:
- Macro WRITE_VERIFY_EN.
- Defined:
  - After WHOLD, a write continues through RSEL and RCAP (mem_rw=0) to read the word back.
  - rsp_rdata = readback value.
  - rsp_err = 1 if the readback differs from the written data.
  - Write latency becomes T+5+WR_HOLD.
- Not defined:
  - Writes go WHOLD to RESP with rsp_err=0 and rsp_rdata=0.
  - rsp_err is driven only by the out-of-range check.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 for 2 cycles, then release.
  - Required response: mem_sel=0, mem_rw=0, rsp_valid=0, req_ready=1, busy=0.
- Write then read:
  - Stimulus: write addr=3, data=8'hA5; then read addr=3.
  - Required response on the write: mem_sel=16'h0008 for exactly 2 cycles with mem_rw=1, and rsp_valid at T+5.
  - Required response on the read: rsp_rdata=8'hA5, rsp_err=0, rsp_valid at T+4.
- Out of range:
  - Stimulus: N_WORDS=12, read addr=13.
  - Required response: rsp_err=1, rsp_rdata=0, and mem_sel stays 0 throughout.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles during RESP while presenting a second request.
  - Required response: rsp_rdata and rsp_err stay stable, req_ready stays 0, and the second request is accepted the cycle after the response handshake.
- Reset mid-write:
  - Stimulus: rst_n=0 during WPULSE.
  - Required response: the next cycle shows mem_sel=0, mem_rw=0, state IDLE, and no rsp_valid.
- Verify (WRITE_VERIFY_EN defined):
  - Stimulus: the model forces bit 0 of word 5 stuck at 0; write 8'hFF to addr 5.
  - Required response: rsp_err=1, rsp_rdata=8'hFE.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: request sequencer for the mem_word latch array with safe setup/pulse/hold timing
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready/req_we/req_addr/req_wdata request handshake;
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err response handshake; mem_rw/mem_sel/mem_wdata drive the
//        array, mem_rdata returns word i at [i*DATA_W +: DATA_W]; busy is high outside IDLE.
// Option: define WRITE_VERIFY_EN to read every written word back and flag a mismatch in rsp_err.
module mem_ctrl #(
    parameter int N_WORDS = 16,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int WR_HOLD = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic                        mem_rw,
    output logic [N_WORDS-1:0]          mem_sel,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [N_WORDS*DATA_W-1:0]   mem_rdata,
    output logic                        busy
);
    typedef enum logic [2:0] {IDLE, SETUP, WPULSE, WHOLD, RSEL, RCAP, RESP} state_t;
    localparam int CNT_W = $clog2(WR_HOLD + 1);
    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                oor;
    logic [N_WORDS-1:0]  onehot;
    logic [DATA_W-1:0]   rd_word;

    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign oor       = int'(addr_q) >= N_WORDS;

    always_comb begin
        onehot  = '0;
        rd_word = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            onehot[i] = int'(addr_q) == i;
            if (int'(addr_q) == i) rd_word = mem_rdata[i*DATA_W +: DATA_W];
        end
    end

    // mem_wdata is loaded on accept and held until the next write, so it doubles as the
    // reference for the readback comparison.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_rw    <= 1'b0;
            mem_sel   <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q   <= req_we;
                    addr_q <= req_addr;
                    mem_rw <= req_we;
                    if (req_we) mem_wdata <= req_wdata;
                    state  <= SETUP;
                end
                SETUP: begin
                    cnt <= '0;
                    if (oor) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        mem_rw    <= 1'b0;
                    end else begin
                        mem_sel <= onehot;
                        state   <= we_q ? WPULSE : RSEL;
                    end
                end
                WPULSE: if (cnt == CNT_W'(WR_HOLD - 1)) begin
                    state   <= WHOLD;
                    mem_sel <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                WHOLD: begin
                    mem_rw <= 1'b0;
`ifdef WRITE_VERIFY_EN
                    mem_sel <= onehot;
                    state   <= RSEL;
`else
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
`endif
                end
                RSEL: state <= RCAP;
                RCAP: begin
                    state     <= RESP;
                    mem_sel   <= '0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= rd_word;
`ifdef WRITE_VERIFY_EN
                    rsp_err   <= we_q && (rd_word != mem_wdata);
`else
                    rsp_err   <= 1'b0;
`endif
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized self-checking bench for mem_ctrl against a word-array reference model
module tb_mem_ctrl;
    localparam int NW = 12, AW = 4, DW = 8, WRH = 2;
`ifdef WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
    localparam logic [7:0] STUCK5 = 8'h01;
`else
    localparam bit VERIFY = 1'b0;
    localparam logic [7:0] STUCK5 = 8'h00;
`endif
    logic clk, rst_n, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, mem_rw, busy;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata, rsp_rdata, mem_wdata;
    logic [NW-1:0] mem_sel;
    logic [NW*DW-1:0] mem_rdata;
    logic [DW-1:0] mem [NW];
    logic [DW-1:0] ref_mem [16];
    logic wipe;
    int checks = 0, errors = 0;

    mem_ctrl #(.N_WORDS(NW), .ADDR_W(AW), .DATA_W(DW), .WR_HOLD(WRH)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_rw(mem_rw), .mem_sel(mem_sel),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word array: a selected word in write mode takes the data bus; word 5 may carry a stuck-at-0 bit.
    always @(posedge clk)
        for (int i = 0; i < NW; i++)
            if (wipe) mem[i] <= '0;
            else if (mem_sel[i] && mem_rw) mem[i] <= mem_wdata & ~((i == 5) ? STUCK5 : 8'h00);

    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < NW; i++) mem_rdata[i*DW +: DW] = mem[i];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [NW-1:0] p_sel;
    logic p_rw;
    logic [DW-1:0] p_wd;
    always @(negedge clk) begin
        if (rst_n && mem_sel != 0) begin
            check("onehot", $countones(mem_sel), 1);
            if (p_sel != 0) begin
                check("rw_stable", mem_rw, p_rw);
                check("wd_stable", mem_wdata, p_wd);
            end
        end
        p_sel <= mem_sel;
        p_rw  <= mem_rw;
        p_wd  <= mem_wdata;
    end

    task automatic issue(input logic we, input logic [3:0] addr, input logic [7:0] data);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Called one cycle after acceptance; optionally presents a pending read during backpressure.
    task automatic run_rsp(input logic we, input logic [3:0] addr, input logic [7:0] data,
                           input int hold, input bit pend, input logic [3:0] pa);
        logic [7:0] er;
        logic ee;
        int el, lat, sw, sr;
        if (addr >= NW) begin
            er = 0; ee = 1; el = 2;
        end else if (!we) begin
            er = ref_mem[addr]; ee = 0; el = 4;
        end else begin
            ref_mem[addr] = data & ~((addr == 5) ? STUCK5 : 8'h00);
            er = VERIFY ? ref_mem[addr] : 8'h00;
            ee = VERIFY && (ref_mem[addr] != data);
            el = VERIFY ? 5 + WRH : 3 + WRH;
        end
        lat = 1; sw = 0; sr = 0;
        while (!rsp_valid && lat < 40) begin
            if (mem_sel != 0) begin
                check("sel_addr", mem_sel, 32'(1) << addr);
                if (mem_rw) sw++; else sr++;
            end
            req_we = 1'($urandom); req_addr = 4'($urandom); req_wdata = 8'($urandom);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, el);
        check("sel_wr_cycles", sw, (addr < NW && we) ? WRH : 0);
        check("sel_rd_cycles", sr, (addr < NW && (!we || VERIFY)) ? 2 : 0);
        check("rdata", rsp_rdata, er);
        check("err", rsp_err, ee);
        for (int i = 0; i < hold; i++) begin
            if (pend) begin
                req_valid = 1'b1; req_we = 1'b0; req_addr = pa;
            end
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, er);
            check("hold_err", rsp_err, ee);
            if (pend) check("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", rsp_valid, 0);
        check("idle_ready", req_ready, 1);
        if (pend) begin
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            check("pend_accept", busy, 1);
        end
    endtask

    task automatic txn(input logic we, input logic [3:0] addr, input logic [7:0] data, input int hold);
        issue(we, addr, data);
        run_rsp(we, addr, data, hold, 1'b0, 4'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        rst_n = 1'b0; wipe = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; wipe = 1'b0;
        @(negedge clk);
        check("rst_sel", mem_sel, 0);
        check("rst_rw", mem_rw, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);
        check("rst_wdata", mem_wdata, 0);

        txn(1'b1, 4'd3, 8'hA5, 0);
        txn(1'b0, 4'd3, 8'h00, 0);
        txn(1'b0, 4'd13, 8'h00, 1);
        txn(1'b1, 4'd4, 8'h5A, 0);
        issue(1'b0, 4'd4, 8'h00);
        run_rsp(1'b0, 4'd4, 8'h00, 5, 1'b1, 4'd3);
        run_rsp(1'b0, 4'd3, 8'h00, 0, 1'b0, 4'd0);
        txn(1'b1, 4'd5, 8'hFF, 0);
        txn(1'b0, 4'd5, 8'h00, 0);

        issue(1'b1, 4'd7, 8'h3C);
        @(negedge clk);
        check("mid_sel", mem_sel, 12'h080);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ref_mem[7] = 8'h3C;
        check("mid_rst_sel", mem_sel, 0);
        check("mid_rst_rw", mem_rw, 0);
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_ready", req_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid2", rsp_valid, 0);
        txn(1'b0, 4'd7, 8'h00, 0);

        repeat (80) txn(1'($urandom), 4'($urandom_range(0, 13)), 8'($urandom), $urandom_range(0, 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
